cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares one physical-memory cacheline port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Sits below both caches and above the cacheline adaptor / physical memory.
- Serves one transaction at a time. Latches the command at grant and routes the response back to the granted requester only.
- Data requests win ties, bounded by a starvation limit so instruction misses always make progress.

Parameters:
- LINE_W, 256, cacheline width in bits.
- STARVE_MAX, 4, maximum consecutive data grants while an instruction request waits; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0.
- icache_read  in  1  instruction-cache line fill request.
- icache_addr  in  32  line address, bits [4:0] ignored.
- icache_rdata  out  LINE_W  fill data.
- icache_resp  out  1  one-cycle completion pulse to the instruction cache.
- dcache_read  in  1  data-cache line fill request.
- dcache_write  in  1  data-cache writeback request.
- dcache_addr  in  32  line address.
- dcache_wdata  in  LINE_W  writeback data.
- dcache_rdata  out  LINE_W  fill data.
- dcache_resp  out  1  one-cycle completion pulse to the data cache.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_addr  out  32  line-aligned address; bits [4:0] are forced to 0.
- pmem_wdata  out  LINE_W  write data.
- pmem_rdata  in  LINE_W  read data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- Reset (rst = 0, async):
  - State goes to IDLE; starve_cnt = 0.
  - Latched addr, wdata and op are cleared to 0.
  - All outputs are 0.
- IDLE arbitration, decided in the same cycle the request is seen, state change on the next edge:
  - data request = dcache_read OR dcache_write.
  - data request only → SERVE_D.
  - icache_read only → SERVE_I.
  - Both requests, starve_cnt < STARVE_MAX → SERVE_D, and starve_cnt increments.
  - Both requests, starve_cnt == STARVE_MAX → SERVE_I.
  - Granting SERVE_I clears starve_cnt.
  - Granting SERVE_D while icache_read is low clears starve_cnt.
- Latch on grant edge: requester addr (bits [4:0] zeroed), op, and wdata for a data write.
  - dcache_read and dcache_write both high is illegal. Treat it as a write.
- SERVE_x drive:
  - pmem_read/pmem_write come from the latched op and are held constant until pmem_resp.
  - pmem_addr and pmem_wdata come from the latched registers.
  - First command cycle is one cycle after the request is seen in IDLE.
- Completion:
  - On the pmem_resp cycle, the granted x_resp = 1 combinationally and x_rdata = pmem_rdata.
  - The other requester's resp stays 0; its rdata is 0.
  - Next state is RELEASE.
- RELEASE:
  - All pmem commands are 0.
  - Lasts one cycle, giving the requester time to drop its request. Then IDLE.
  - Back-to-back transactions are spaced by at least 2 idle cycles at pmem: RELEASE then IDLE.
- Requester drops its request mid-transaction: the transaction still runs to pmem_resp, because memory cannot abort. The resp pulse is still issued, then RELEASE.
- pmem_resp outside SERVE_x is ignored; no resp is forwarded.
- Async reset mid-transaction:
  - Commands drop immediately.
  - The in-flight memory transaction is abandoned; memory is reset alongside.
- starve_cnt saturates at STARVE_MAX and never wraps.
- Outputs in IDLE/RELEASE: pmem_read = pmem_write = 0, pmem_addr = 0, pmem_wdata = 0.

Decomposition:
- Shared package (arbiter_types):
  - state enum arb_state_t {IDLE, SERVE_I, SERVE_D, RELEASE}.
  - enum arb_op_t {OP_NONE, OP_READ, OP_WRITE}.
  - LINE_W default constant.
  - Counter width derived as $clog2(STARVE_MAX+1).
- One natural sub-module: arb_priority, a combinational grant decision from (icache_read, dcache_req, starve_cnt) to grant_i/grant_d plus next counter value.
- FSM, latches and response muxing live in the top.

Test Plan:
- icache_read alone, addr 0x0000_1234, pmem_resp after 3 cycles with rdata = {8{32'hDEADBEEF}}:
  - pmem_read high from cycle 1 with pmem_addr = 0x0000_1220.
  - icache_resp = 1 with matching rdata on the resp cycle.
  - dcache_resp stays 0.
- dcache_write alone, addr 0x8000_0040, wdata pattern A5…: pmem_write = 1 with latched wdata; dcache_resp pulses once; state is IDLE 2 cycles after resp.
- icache_read and dcache_read asserted together and held, every pmem_resp after 1 cycle:
  - Grant order is D,D,D,D,I,D,… for STARVE_MAX = 4.
  - starve_cnt is 0 after the I grant.
- dcache_addr changes to 0xFFFF_FFE0 mid-transaction: pmem_addr stays at the original latched value until resp.
- rst driven low in SERVE_D, off-edge: pmem_write falls to 0 immediately without a clock; after release the first request is granted normally.
- Spurious pmem_resp in IDLE: no icache_resp or dcache_resp, state stays IDLE.

Source files
------------

// File: rtl/arbiter_types.sv
// arbiter_types: shared state/op encodings and sizing helpers for the cacheline arbiter
package arbiter_types;
    localparam int DEFAULT_LINE_W = 256;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} arb_op_t;
    function automatic int cnt_width(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction
endpackage

// File: rtl/arb_priority.sv
// arb_priority: data-first grant decision bounded by the instruction starvation limit
module arb_priority
    import arbiter_types::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             icache_read,
    input  logic             dcache_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i,
    output logic             grant_d,
    output logic [CNT_W-1:0] starve_nxt
);
    always_comb begin
        grant_d    = dcache_req && (!icache_read || starve_cnt < CNT_W'(STARVE_MAX));
        grant_i    = icache_read && !grant_d;
        starve_nxt = (grant_d && icache_read) ? starve_cnt + CNT_W'(1) : (grant_i || grant_d) ? '0 : starve_cnt;
    end
endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline memory port between the icache and dcache miss paths
module cacheline_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W     = DEFAULT_LINE_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [31:0]       icache_addr,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [31:0]       dcache_addr,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int CNT_W = cnt_width(STARVE_MAX);
    arb_state_t        state, state_nxt;
    arb_op_t           op_q;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              grant_i, grant_d, serving;
    arb_priority #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_prio (
        .icache_read(icache_read),
        .dcache_req (dcache_read || dcache_write),
        .starve_cnt (starve_cnt),
        .grant_i    (grant_i),
        .grant_d    (grant_d),
        .starve_nxt (starve_nxt)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_NONE;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                starve_cnt <= starve_nxt;
            // a simultaneous read+write from the dcache is resolved as a write
            if (state == IDLE && grant_d) begin
                addr_q  <= dcache_addr & ~32'h1F;
                op_q    <= dcache_write ? OP_WRITE : OP_READ;
                wdata_q <= dcache_write ? dcache_wdata : '0;
            end else if (state == IDLE && grant_i) begin
                addr_q  <= icache_addr & ~32'h1F;
                op_q    <= OP_READ;
                wdata_q <= '0;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:             state_nxt = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
            SERVE_I, SERVE_D: state_nxt = pmem_resp ? RELEASE : state;
            RELEASE:          state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
        serving      = state == SERVE_I || state == SERVE_D;
        pmem_read    = serving && op_q == OP_READ;
        pmem_write   = serving && op_q == OP_WRITE;
        pmem_addr    = serving ? addr_q : '0;
        pmem_wdata   = serving ? wdata_q : '0;
        icache_resp  = state == SERVE_I && pmem_resp;
        dcache_resp  = state == SERVE_D && pmem_resp;
        icache_rdata = icache_resp ? pmem_rdata : '0;
        dcache_rdata = dcache_resp ? pmem_rdata : '0;
    end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed scoreboard bench for the cacheline arbiter
module tb_cacheline_arbiter;
    import arbiter_types::*;
    localparam int LW = 256;
    typedef struct {
        logic          is_i;
        logic [31:0]   addr;
        logic          wr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;
    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
    logic [31:0]   icache_addr, dcache_addr, pmem_addr;
    logic [LW-1:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            pops = 0;
    logic          mem_en, spur_resp;
    int            mem_lat;
    logic [LW-1:0] rd_base, spur_rdata;

    cacheline_arbiter #(.LINE_W(LW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic is_i, input logic [31:0] a, input logic wr,
                        input logic [LW-1:0] wd, input logic [LW-1:0] rd);
        exp_t e;
        e.is_i = is_i; e.addr = a; e.wr = wr; e.wdata = wd; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic wait_pops(input int n);
        for (int k = 0; k < 200 && pops < n; k++) @(posedge clk);
        check("resp_wait", LW'(pops >= n), LW'(1));
    endtask

    // memory model: answers after mem_lat command cycles, or replays spur_resp when disabled
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (!mem_en) begin
                lat_cnt = 0;
                pmem_resp = spur_resp;
            end else if (pmem_read || pmem_write) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    pmem_resp = 1'b1;
                    lat_cnt = 0;
                end
            end else
                lat_cnt = 0;
            pmem_rdata = !pmem_resp ? '0 : mem_en ? rd_base : spur_rdata;
        end
    end

    // scoreboard monitor: every command cycle and response is checked against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if ((pmem_read || pmem_write) && sb.size() > 0) begin
                    e = sb[0];
                    check("cmd_read", LW'(pmem_read), LW'(!e.wr));
                    check("cmd_write", LW'(pmem_write), LW'(e.wr));
                    check("cmd_addr", LW'(pmem_addr), LW'(e.addr));
                    if (e.wr) check("cmd_wdata", pmem_wdata, e.wdata);
                    if (pmem_resp) begin
                        void'(sb.pop_front());
                        check("i_resp", LW'(icache_resp), LW'(e.is_i));
                        check("d_resp", LW'(dcache_resp), LW'(!e.is_i));
                        check("i_rdata", icache_rdata, e.is_i ? e.rdata : '0);
                        check("d_rdata", dcache_rdata, e.is_i ? '0 : e.rdata);
                        pops++;
                    end else
                        check("early_resp", LW'({icache_resp, dcache_resp}), '0);
                end else begin
                    check("idle_cmd", LW'({pmem_read, pmem_write}), '0);
                    check("idle_resp", LW'({icache_resp, dcache_resp}), '0);
                    check("idle_rdata", icache_rdata | dcache_rdata, '0);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        icache_read = 1'b0; icache_addr = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_addr = '0; dcache_wdata = '0;
        mem_en = 1'b1; mem_lat = 1; spur_resp = 1'b0; rd_base = '0; spur_rdata = '0;
        @(posedge clk); #1;
        check("rst_state", LW'(dut.state), LW'(IDLE));
        check("rst_starve", LW'(dut.starve_cnt), '0);
        check("rst_pmem_cmd", LW'({pmem_read, pmem_write}), '0);
        check("rst_pmem_addr", LW'(pmem_addr), '0);
        check("rst_pmem_wdata", pmem_wdata, '0);
        check("rst_resps", LW'({icache_resp, dcache_resp}), '0);
        check("rst_rdata", icache_rdata | dcache_rdata, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        // instruction fill alone
        mem_lat = 3; rd_base = {8{32'hDEADBEEF}};
        icache_addr = 32'h0000_1234; icache_read = 1'b1;
        push(1'b1, 32'h0000_1220, 1'b0, '0, rd_base);
        #3 check("i_cycle0_read", LW'(pmem_read), '0);
        @(posedge clk); #1;
        check("i_cycle1_read", LW'(pmem_read), LW'(1));
        check("i_cycle1_addr", LW'(pmem_addr), LW'(32'h0000_1220));
        check("i_state", LW'(dut.state), LW'(SERVE_I));
        wait_pops(1);
        #1 icache_read = 1'b0;
        check("i_release", LW'(dut.state), LW'(RELEASE));
        @(posedge clk); #1;
        // data writeback alone
        mem_lat = 2; dcache_addr = 32'h8000_0040; dcache_wdata = {32{8'hA5}}; dcache_write = 1'b1;
        push(1'b0, 32'h8000_0040, 1'b1, {32{8'hA5}}, rd_base);
        @(posedge clk); #1;
        check("d_write_cmd", LW'(pmem_write), LW'(1));
        check("d_write_data", pmem_wdata, {32{8'hA5}});
        wait_pops(2);
        #1 dcache_write = 1'b0; dcache_wdata = '0;
        check("d_release", LW'(dut.state), LW'(RELEASE));
        check("d_release_cmd", LW'(pmem_write), '0);
        @(posedge clk); #1;
        check("d_idle_after_resp", LW'(dut.state), LW'(IDLE));
        // contention: D,D,D,D,I,D
        mem_lat = 1; rd_base = {8{32'h0123_4567}};
        icache_addr = 32'h0000_4000; dcache_addr = 32'h0000_5000;
        for (int k = 0; k < 6; k++) push(k == 4, (k == 4) ? 32'h0000_4000 : 32'h0000_5000, 1'b0, '0, rd_base);
        icache_read = 1'b1; dcache_read = 1'b1;
        wait_pops(7);
        #1 check("starve_after_i", LW'(dut.starve_cnt), '0);
        wait_pops(8);
        #1 icache_read = 1'b0; dcache_read = 1'b0;
        check("starve_after_d", LW'(dut.starve_cnt), LW'(1));
        check("contention_drained", LW'(sb.size()), '0);
        @(posedge clk); #1;
        // address changes mid-transaction
        mem_lat = 4; rd_base = {8{32'hCAFE_F00D}};
        dcache_addr = 32'h0000_2040; dcache_read = 1'b1;
        push(1'b0, 32'h0000_2040, 1'b0, '0, rd_base);
        repeat (2) @(posedge clk);
        #1 dcache_addr = 32'hFFFF_FFE0;
        #1 check("addr_hold", LW'(pmem_addr), LW'(32'h0000_2040));
        wait_pops(9);
        #1 dcache_read = 1'b0;
        @(posedge clk); #1;
        // asynchronous reset while serving a write
        mem_en = 1'b0;
        dcache_addr = 32'h9000_0000; dcache_wdata = {8{32'h5A5A_0F0F}}; dcache_write = 1'b1;
        push(1'b0, 32'h9000_0000, 1'b1, {8{32'h5A5A_0F0F}}, '0);
        repeat (2) @(posedge clk);
        #1 check("rst_pre_write", LW'(pmem_write), LW'(1));
        #2 rst = 1'b0;
        sb.delete();
        dcache_write = 1'b0;
        #1;
        check("rst_mid_write", LW'(pmem_write), '0);
        check("rst_mid_addr", LW'(pmem_addr), '0);
        check("rst_mid_wdata", pmem_wdata, '0);
        check("rst_mid_state", LW'(dut.state), LW'(IDLE));
        check("rst_mid_addr_q", LW'(dut.addr_q), '0);
        check("rst_mid_wdata_q", LW'(dut.wdata_q), '0);
        @(posedge clk); #1;
        rst = 1'b1; mem_en = 1'b1; mem_lat = 2; rd_base = {8{32'h7777_8888}};
        @(posedge clk); #1;
        icache_addr = 32'h0000_3010; icache_read = 1'b1;
        push(1'b1, 32'h0000_3000, 1'b0, '0, rd_base);
        @(posedge clk); #1;
        check("post_rst_state", LW'(dut.state), LW'(SERVE_I));
        check("post_rst_read", LW'(pmem_read), LW'(1));
        wait_pops(10);
        #1 icache_read = 1'b0;
        @(posedge clk); #1;
        // spurious memory response while idle
        mem_en = 1'b0; spur_rdata = {8{32'h1111_2222}}; spur_resp = 1'b1;
        #3;
        check("spur_i_resp", LW'(icache_resp), '0);
        check("spur_d_resp", LW'(dcache_resp), '0);
        check("spur_rdata", icache_rdata | dcache_rdata, '0);
        @(posedge clk); #1;
        spur_resp = 1'b0;
        check("spur_state", LW'(dut.state), LW'(IDLE));
        @(posedge clk); #1;
        check("spur_state_later", LW'(dut.state), LW'(IDLE));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
